// File: rtl/memarb.sv
// memarb: N-channel external memory arbiter with a fixed-length setup/strobe/hold bus cycle.
// Optional MEMARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module memarb #(
    parameter int NCH  = 2,
    parameter int AW   = 16,
    parameter int MAW  = 23,
    parameter int WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_fl,
    input  logic [NCH-1:0]    ch_we,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*16-1:0] ch_wdata,
    output logic [NCH*16-1:0] ch_rdata,
    output logic [NCH-1:0]    ch_rdy,
    output logic [MAW:1]      memaddr,
    inout  wire  [15:0]       memdata,
    output logic              memoe,
    output logic              memrw,
    output logic              memflcs,
    output logic              memramcs
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [AW-1:0] addr_a  [NCH];
    logic [15:0]   wdata_a [NCH];
    logic [15:0]   rdata_q [NCH];
    logic [15:0]   rdata_d [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign addr_a[gi]              = ch_addr[gi*AW +: AW];
            assign wdata_a[gi]             = ch_wdata[gi*16 +: 16];
            assign ch_rdata[gi*16 +: 16]   = rdata_q[gi];
        end
    endgenerate

    logic [1:0]     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [GW-1:0]  g_q, g_d;
    logic [15:0]    wdata_q, wdata_d;
    logic           we_q, we_d, fl_q, fl_d;
    logic [MAW-1:0] maddr_q, maddr_d;
    logic [NCH-1:0] rdy_q, rdy_d;
    logic           oe_q, oe_d, rw_q, rw_d, flcs_q, flcs_d, ramcs_q, ramcs_d;
    logic           drv_q, drv_d;
    logic           busy;
    logic [GW-1:0]  gnt;

`ifdef MEMARB_FIXED_PRIO_EN
    always_comb begin
        gnt = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (ch_req[k]) gnt = GW'(k);
        end
    end
`else
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] idx;
    logic          found;

    // Search starts at rr_ptr and wraps, so the last winner goes to the back of the line.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = GW'((int'(rr_ptr_q) + k) % NCH);
            if (!found && ch_req[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        fl_d    = fl_q;
        maddr_d = maddr_q;
        rdy_d   = '0;
        rdata_d = rdata_q;
`ifndef MEMARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|ch_req) begin
                    g_d     = gnt;
                    wdata_d = wdata_a[gnt];
                    we_d    = ch_we[gnt];
                    fl_d    = ch_fl[gnt];
                    maddr_d = (MAW'(gnt) << AW) | MAW'(addr_a[gnt]);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = 4'(WAIT - 1);
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_HOLD;
                    rdy_d[g_q] = 1'b1;
                    if (!we_q) rdata_d[g_q] = memdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
`ifndef MEMARB_FIXED_PRIO_EN
                rr_ptr_d = (g_q == GW'(NCH - 1)) ? '0 : g_q + 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Bus strobes are registered from the next state; flash writes never assert flash CS or write strobe.
        busy    = (state_d != S_IDLE);
        ramcs_d = !(busy && !fl_d);
        flcs_d  = !(busy && fl_d && !we_d);
        oe_d    = !(state_d == S_ACCESS && !we_d);
        rw_d    = !(state_d == S_ACCESS && we_d && !fl_d);
        drv_d   = busy && we_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            g_q     <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            fl_q    <= 1'b0;
            maddr_q <= '0;
            rdy_q   <= '0;
            oe_q    <= 1'b1;
            rw_q    <= 1'b1;
            flcs_q  <= 1'b1;
            ramcs_q <= 1'b1;
            drv_q   <= 1'b0;
            for (int k = 0; k < NCH; k++) rdata_q[k] <= '0;
`ifndef MEMARB_FIXED_PRIO_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            fl_q    <= fl_d;
            maddr_q <= maddr_d;
            rdy_q   <= rdy_d;
            oe_q    <= oe_d;
            rw_q    <= rw_d;
            flcs_q  <= flcs_d;
            ramcs_q <= ramcs_d;
            drv_q   <= drv_d;
            for (int k = 0; k < NCH; k++) rdata_q[k] <= rdata_d[k];
`ifndef MEMARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign ch_rdy   = rdy_q;
    assign memaddr  = maddr_q;
    assign memoe    = oe_q;
    assign memrw    = rw_q;
    assign memflcs  = flcs_q;
    assign memramcs = ramcs_q;
    assign memdata  = drv_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_memarb.sv
// Directed self-checking bench for memarb (NCH=2, AW=16, MAW=23, WAIT=2).
module tb_memarb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_req, ch_fl, ch_we;
    logic [31:0] ch_addr, ch_wdata;
    logic [31:0] ch_rdata;
    logic [1:0]  ch_rdy;
    logic [22:0] memaddr;
    wire  [15:0] memdata;
    logic        memoe, memrw, memflcs, memramcs;
    logic        probe;
    logic [15:0] bus_val;

    int n_chk  = 0;
    int n_fail = 0;
    int ev_cyc [8];
    int ev_ch  [8];
    int n_ev;
    int got_cyc;

    memarb #(.NCH(2), .AW(16), .MAW(23), .WAIT(2)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_fl(ch_fl), .ch_we(ch_we),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_rdy(ch_rdy),
        .memaddr(memaddr), .memdata(memdata), .memoe(memoe), .memrw(memrw),
        .memflcs(memflcs), .memramcs(memramcs)
    );

    always #5 clk = ~clk;

    // External memory model: fixed word at 0x1234, inverted address elsewhere; probe drives a marker.
    assign bus_val = (memaddr == 23'h001234) ? 16'hBEEF : ~memaddr[15:0];
    assign memdata = probe ? 16'h0F0F : (!memoe ? bus_val : 16'hzzzz);

    always @(negedge clk)
        if (ch_rdy != 2'b00)
            $display("txn rdy=%b addr=%h rdata0=%h rdata1=%h", ch_rdy, memaddr, ch_rdata[15:0], ch_rdata[31:16]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe_z(input string tag);
        probe = 1'b1;
        #1;
        check(tag, {16'h0, memdata}, 32'h0F0F);
        probe = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; ch_req = '0; ch_fl = '0; ch_we = '0;
        ch_addr = '0; ch_wdata = '0; probe = 1'b0;
        tick(); tick();
        check("rst_strobes", {28'h0, memoe, memrw, memflcs, memramcs}, 32'hF);
        check("rst_addr", {9'h0, memaddr}, 32'h0);
        check("rst_rdy", {30'h0, ch_rdy}, 32'h0);
        check("rst_rdata", ch_rdata, 32'h0);
        probe_z("rst_bus_z");

        // ch0 RAM read of 0x1234
        rst = 1'b0; ch_req = 2'b01; ch_addr[15:0] = 16'h1234;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("rd_ramcs_c%0d", c), {31'h0, memramcs}, (c <= 4) ? 32'h0 : 32'h1);
            check($sformatf("rd_oe_c%0d", c), {31'h0, memoe}, (c == 2 || c == 3) ? 32'h0 : 32'h1);
            check($sformatf("rd_rdy_c%0d", c), {30'h0, ch_rdy}, (c == 4) ? 32'h1 : 32'h0);
            if (c == 1) check("rd_addr", {9'h0, memaddr}, 32'h001234);
            if (c == 4) begin
                check("rd_data", {16'h0, ch_rdata[15:0]}, 32'hBEEF);
                ch_req = 2'b00;
            end
        end

        // ch1 RAM write of 0xA55A to 0x0010
        ch_req = 2'b10; ch_we = 2'b10; ch_addr[31:16] = 16'h0010; ch_wdata[31:16] = 16'hA55A;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("wr_rw_c%0d", c), {31'h0, memrw}, (c == 2 || c == 3) ? 32'h0 : 32'h1);
            check($sformatf("wr_rdy_c%0d", c), {30'h0, ch_rdy}, (c == 4) ? 32'h2 : 32'h0);
            if (c == 1) check("wr_addr", {9'h0, memaddr}, 32'h010010);
            if (c <= 4) check($sformatf("wr_data_c%0d", c), {16'h0, memdata}, 32'hA55A);
            if (c == 4) ch_req = 2'b00;
            if (c == 5) probe_z("wr_bus_z");
        end
        check("wr_hold_rdata", ch_rdata, 32'h0000BEEF);

        // Both channels requesting continuously
        ch_we = 2'b00; ch_addr = {16'h0003, 16'h0002}; ch_req = 2'b11; n_ev = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (ch_rdy != 2'b00 && n_ev < 8) begin
                ev_cyc[n_ev] = c;
                ev_ch[n_ev]  = (ch_rdy == 2'b01) ? 0 : (ch_rdy == 2'b10) ? 1 : 9;
                n_ev++;
                if (n_ev == 4) ch_req = 2'b00;
            end
        end
        check("arb_count", n_ev, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("arb_cyc%0d", i), ev_cyc[i], 4 + 5 * i);
`ifdef MEMARB_FIXED_PRIO_EN
            check($sformatf("arb_ch%0d", i), ev_ch[i], 0);
`else
            check($sformatf("arb_ch%0d", i), ev_ch[i], i % 2);
`endif
        end
`ifdef MEMARB_FIXED_PRIO_EN
        check("arb_rdata", ch_rdata, 32'h0000FFFD);
`else
        check("arb_rdata", ch_rdata, 32'hFFFCFFFD);
`endif
        tick();

        // ch0 flash write is write-protected
        ch_req = 2'b01; ch_fl = 2'b01; ch_we = 2'b01; ch_addr[15:0] = 16'h0100; ch_wdata[15:0] = 16'h1234;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("fw_cs_rw_c%0d", c), {29'h0, memflcs, memrw, memramcs}, 32'h7);
            check($sformatf("fw_rdy_c%0d", c), {30'h0, ch_rdy}, (c == 4) ? 32'h1 : 32'h0);
            if (c == 4) ch_req = 2'b00;
        end
        check("fw_rdata", {16'h0, ch_rdata[15:0]}, 32'hFFFD);

        // Reset in the middle of a ch1 read
        ch_fl = 2'b00; ch_we = 2'b00; ch_addr[31:16] = 16'h0020; ch_req = 2'b10;
        tick(); tick();
        check("rm_oe_active", {31'h0, memoe}, 32'h0);
        rst = 1'b1;
        tick();
        check("rm_strobes", {28'h0, memoe, memrw, memflcs, memramcs}, 32'hF);
        check("rm_rdy", {30'h0, ch_rdy}, 32'h0);
        check("rm_rdata", ch_rdata, 32'h0);
        probe_z("rm_bus_z");
        rst = 1'b0; ch_req = 2'b11; ch_addr[15:0] = 16'h1234; got_cyc = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ch_rdy != 2'b00 && got_cyc == 0) begin
                got_cyc = c;
                check("rm_first_grant", {30'h0, ch_rdy}, 32'h1);
                check("rm_first_data", {16'h0, ch_rdata[15:0]}, 32'hBEEF);
                ch_req = 2'b00;
            end
        end
        check("rm_first_cyc", got_cyc, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/memarb.md
# memarb

Parametrised N-channel external memory arbiter, successor to the fixed PPU pass-through multiplexer. It sits between the processor bus adapters (PPU, CPU, and later a DMA/video fetch channel) and the shared 16-bit external RAM/flash bus. It grants one channel at a time under round-robin, runs a fixed-length setup/strobe/hold access cycle, and returns a one-cycle ready pulse with captured read data per channel.

## Interface
Parameters:
- NCH, 2, number of requesting channels (2..4); channel 0 = PPU, 1 = CPU.
- AW, 16, per-channel word-address width.
- MAW, 23, top bit of external word address memaddr[MAW:1]; MAW >= AW + clog2(NCH).
- WAIT, 2, strobe-active cycles per access (1..15).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- ch_req  in  NCH  access request per channel, level, held until ready.
- ch_fl  in  NCH  1 = flash target, 0 = RAM target.
- ch_we  in  NCH  1 = write, 0 = read.
- ch_addr  in  NCH*AW  word addresses, channel i at [i*AW +: AW].
- ch_wdata  in  NCH*16  write data, channel i at [i*16 +: 16].
- ch_rdata  out  NCH*16  read data, held per channel until that channel's next read completes.
- ch_rdy  out  NCH  one-cycle completion pulse per channel.
- memaddr  out  MAW  external word address, bits [MAW:1].
- memdata  inout  16  external data bus.
- memoe  out  1  output enable, active-low.
- memrw  out  1  write strobe, active-low.
- memflcs  out  1  flash chip select, active-low.
- memramcs  out  1  RAM chip select, active-low.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE: if any ch_req, grant g = first requesting channel at or after rr_ptr (wrapping); latch g, addr, wdata, we, fl; go SETUP. No request: stay IDLE, all strobes/selects high.
- SETUP: memaddr = {g zero-extended, ch_addr[g]}; selected CS low; memoe, memrw high.
- ACCESS: WAIT cycles, counter from WAIT-1 down to 0; read: memoe low; write: memrw low. Last cycle captures memdata into read latch.
- HOLD: strobes high, CS still low; ch_rdy[g]=1; ch_rdata[g] updated on reads; rr_ptr = g+1 mod NCH; go IDLE.
- memdata driven with latched wdata from SETUP through HOLD on writes only; otherwise high-Z.
- Flash write (fl=1, we=1): write-protected; memflcs, memrw stay high through the whole sequence, ch_rdy still pulses at the normal time.
- memaddr holds last value in IDLE; unused upper bits are zero.

## Timing
- Reset: state IDLE, rr_ptr 0, ch_rdy 0, ch_rdata 0, memoe/memrw/memflcs/memramcs 1, memaddr 0, memdata high-Z. Reset mid-access aborts: all strobes high at the next edge, no ch_rdy.
- Request sampled in IDLE at cycle 0 -> SETUP cycle 1 -> ACCESS cycles 2..WAIT+1 -> HOLD cycle WAIT+2 with ch_rdy. Back-to-back grant period WAIT+3 cycles.
- Requester clears ch_req at the edge that samples ch_rdy=1. ch_req still high in the following IDLE cycle starts a new access.
- ch_addr/ch_wdata/ch_we/ch_fl sampled only in IDLE; later changes ignored until next grant.
- Simultaneous requests: rr_ptr decides. All NCH requesting continuously are served 0,1,..,NCH-1,0.
- ch_req dropped mid-access: access completes, ch_rdy still pulses.

## Configuration
- MEMARB_FIXED_PRIO_EN: defined -> fixed priority, lowest-index requesting channel always wins; rr_ptr not implemented. Undefined (default) -> round-robin as above.

## Test plan
- Reset, WAIT=2, ch0 read RAM addr 16'h1234 -> memramcs low cycles 1..4, memoe low cycles 2..3, memaddr = 23'h001234, ch_rdy[0] in cycle 4, ch_rdata[0] = bus model value 16'hBEEF.
- ch1 write RAM 16'h0010 data 16'hA55A -> memaddr 23'h010010, memrw low 2 cycles, memdata = 16'hA55A SETUP..HOLD, then high-Z.
- ch0 and ch1 request together and hold continuously -> grants alternate 0,1,0,1, each ch_rdy 5 cycles apart (WAIT+3).
- ch0 flash write -> memflcs and memrw never low, ch_rdy[0] in cycle 4. With MEMARB_FIXED_PRIO_EN, both requesting continuously -> ch1 starved.
- Assert rst during ACCESS -> next edge all strobes 1, memdata high-Z, no ch_rdy. Next request granted to ch0 first.
